// File: rtl/id_ex_reg.sv
// ID->EX pipeline register: captures the decoded bundle from ID, supports
// hazard stall (hold) and flush (bubble), and counts inserted bubbles.
module id_ex_reg #(
  parameter int INST_WIDTH       = 32,
  parameter int INST_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int ALU_CTRL_WIDTH   = 1,
  parameter int BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_ID_EX,
  input  logic                        flush_ID_EX,
  input  logic                        valid_ID,
  input  logic [INST_ADDR_WIDTH-1:0]  PC_ID,
  input  logic [INST_ADDR_WIDTH-1:0]  PC_plus_4_ID,
  input  logic [INST_WIDTH-1:0]       INST_ID,
  input  logic [4:0]                  rs1_ID,
  input  logic [4:0]                  rs2_ID,
  input  logic [4:0]                  rd_ID,
  input  logic [DATA_WIDTH-1:0]       imm_ID,
  input  logic [DATA_WIDTH-1:0]       rs1_data_ID,
  input  logic [DATA_WIDTH-1:0]       rs2_data_ID,
  input  logic                        reg_write_ID,
  input  logic                        mem_write_ID,
  input  logic                        uncond_jump_ID,
  input  logic                        meet_branch_ID,
  input  logic                        pc_jal_sel_ID,
  input  logic [1:0]                  result_sel_ID,
  input  logic [1:0]                  alu_sel_0_ID,
  input  logic [1:0]                  alu_sel_1_ID,
  input  logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl_ID,
  output logic [INST_ADDR_WIDTH-1:0]  PC_ID_EX_o,
  output logic [INST_ADDR_WIDTH-1:0]  PC_plus_4_ID_EX_o,
  output logic [INST_WIDTH-1:0]       INST_ID_EX_o,
  output logic [4:0]                  rs1_ID_EX_o,
  output logic [4:0]                  rs2_ID_EX_o,
  output logic [4:0]                  rd_ID_EX_o,
  output logic [DATA_WIDTH-1:0]       imm_ID_EX_o,
  output logic [DATA_WIDTH-1:0]       rs1_data_ID_EX_o,
  output logic [DATA_WIDTH-1:0]       rs2_data_ID_EX_o,
  output logic                        reg_write_ID_EX_o,
  output logic                        mem_write_ID_EX_o,
  output logic                        uncond_jump_ID_EX_o,
  output logic                        meet_branch_ID_EX_o,
  output logic                        pc_jal_sel_ID_EX_o,
  output logic [1:0]                  result_sel_ID_EX_o,
  output logic [1:0]                  alu_sel_0_ID_EX_o,
  output logic [1:0]                  alu_sel_1_ID_EX_o,
  output logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl_ID_EX_o,
  output logic                        valid_ID_EX_o,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_ADDR_WIDTH-1:0] pc_plus_4;
    logic [INST_WIDTH-1:0]      inst;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [DATA_WIDTH-1:0]      imm;
    logic [DATA_WIDTH-1:0]      rs1_data;
    logic [DATA_WIDTH-1:0]      rs2_data;
    logic                       reg_write;
    logic                       mem_write;
    logic                       uncond_jump;
    logic                       meet_branch;
    logic                       pc_jal_sel;
    logic [1:0]                 result_sel;
    logic [1:0]                 alu_sel_0;
    logic [1:0]                 alu_sel_1;
    logic [ALU_CTRL_WIDTH-1:0]  alu_ctrl;
    logic                       valid;
  } stage_t;

  // Bubble is a canonical NOP (addi x0,x0,0) with every side-effect bit clear.
  function automatic stage_t bubble_f();
    stage_t b;
    b      = '0;
    b.inst = INST_WIDTH'(32'h0000_0013);
    return b;
  endfunction

  stage_t                      stage_q, stage_d, load_s;
  logic [BUBBLE_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    load_s             = '0;
    load_s.pc          = PC_ID;
    load_s.pc_plus_4   = PC_plus_4_ID;
    load_s.inst        = INST_ID;
    load_s.rs1         = rs1_ID;
    load_s.rs2         = rs2_ID;
    load_s.rd          = rd_ID;
    load_s.imm         = imm_ID;
    load_s.rs1_data    = rs1_data_ID;
    load_s.rs2_data    = rs2_data_ID;
    load_s.reg_write   = reg_write_ID;
    load_s.mem_write   = mem_write_ID;
    load_s.uncond_jump = uncond_jump_ID;
    load_s.meet_branch = meet_branch_ID;
    load_s.pc_jal_sel  = pc_jal_sel_ID;
    load_s.result_sel  = result_sel_ID;
    load_s.alu_sel_0   = alu_sel_0_ID;
    load_s.alu_sel_1   = alu_sel_1_ID;
    load_s.alu_ctrl    = alu_ctrl_ID;
    load_s.valid       = valid_ID;
  end

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush_ID_EX) begin
      stage_d = bubble_f();
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (!stall_ID_EX) begin
      stage_d = load_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= bubble_f();
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_ID_EX_o          = stage_q.pc;
  assign PC_plus_4_ID_EX_o   = stage_q.pc_plus_4;
  assign INST_ID_EX_o        = stage_q.inst;
  assign rs1_ID_EX_o         = stage_q.rs1;
  assign rs2_ID_EX_o         = stage_q.rs2;
  assign rd_ID_EX_o          = stage_q.rd;
  assign imm_ID_EX_o         = stage_q.imm;
  assign rs1_data_ID_EX_o    = stage_q.rs1_data;
  assign rs2_data_ID_EX_o    = stage_q.rs2_data;
  assign reg_write_ID_EX_o   = stage_q.reg_write;
  assign mem_write_ID_EX_o   = stage_q.mem_write;
  assign uncond_jump_ID_EX_o = stage_q.uncond_jump;
  assign meet_branch_ID_EX_o = stage_q.meet_branch;
  assign pc_jal_sel_ID_EX_o  = stage_q.pc_jal_sel;
  assign result_sel_ID_EX_o  = stage_q.result_sel;
  assign alu_sel_0_ID_EX_o   = stage_q.alu_sel_0;
  assign alu_sel_1_ID_EX_o   = stage_q.alu_sel_1;
  assign alu_ctrl_ID_EX_o    = stage_q.alu_ctrl;
  assign valid_ID_EX_o       = stage_q.valid;
  assign bubble_cnt_o        = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus randomized stall/flush traffic
// checked against a flat-vector reference model and a bubble tally.
module tb_id_ex_reg;
  localparam int OW = 220;

  logic        clk = 1'b0;
  logic        rst, stall_ID_EX, flush_ID_EX, valid_ID;
  logic [31:0] PC_ID, PC_plus_4_ID, INST_ID, imm_ID, rs1_data_ID, rs2_data_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic        reg_write_ID, mem_write_ID, uncond_jump_ID, meet_branch_ID, pc_jal_sel_ID;
  logic [1:0]  result_sel_ID, alu_sel_0_ID, alu_sel_1_ID;
  logic [0:0]  alu_ctrl_ID;

  logic [31:0] PC_o, PC4_o, INST_o, imm_o, rs1d_o, rs2d_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rw_o, mw_o, uj_o, mb_o, pj_o, valid_o;
  logic [1:0]  rs_o, as0_o, as1_o;
  logic [0:0]  ac_o;
  logic [15:0] cnt_o;

  logic [31:0] PC_s, PC4_s, INST_s, imm_s, rs1d_s, rs2d_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic        rw_s, mw_s, uj_s, mb_s, pj_s, valid_s;
  logic [1:0]  rs_s, as0_s, as1_s;
  logic [0:0]  ac_s;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
    .valid_ID(valid_ID), .PC_ID(PC_ID), .PC_plus_4_ID(PC_plus_4_ID), .INST_ID(INST_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .imm_ID(imm_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .reg_write_ID(reg_write_ID), .mem_write_ID(mem_write_ID), .uncond_jump_ID(uncond_jump_ID),
    .meet_branch_ID(meet_branch_ID), .pc_jal_sel_ID(pc_jal_sel_ID),
    .result_sel_ID(result_sel_ID), .alu_sel_0_ID(alu_sel_0_ID), .alu_sel_1_ID(alu_sel_1_ID),
    .alu_ctrl_ID(alu_ctrl_ID),
    .PC_ID_EX_o(PC_o), .PC_plus_4_ID_EX_o(PC4_o), .INST_ID_EX_o(INST_o),
    .rs1_ID_EX_o(rs1_o), .rs2_ID_EX_o(rs2_o), .rd_ID_EX_o(rd_o), .imm_ID_EX_o(imm_o),
    .rs1_data_ID_EX_o(rs1d_o), .rs2_data_ID_EX_o(rs2d_o),
    .reg_write_ID_EX_o(rw_o), .mem_write_ID_EX_o(mw_o), .uncond_jump_ID_EX_o(uj_o),
    .meet_branch_ID_EX_o(mb_o), .pc_jal_sel_ID_EX_o(pj_o),
    .result_sel_ID_EX_o(rs_o), .alu_sel_0_ID_EX_o(as0_o), .alu_sel_1_ID_EX_o(as1_o),
    .alu_ctrl_ID_EX_o(ac_o), .valid_ID_EX_o(valid_o), .bubble_cnt_o(cnt_o)
  );

  id_ex_reg #(.BUBBLE_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
    .valid_ID(valid_ID), .PC_ID(PC_ID), .PC_plus_4_ID(PC_plus_4_ID), .INST_ID(INST_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID), .imm_ID(imm_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .reg_write_ID(reg_write_ID), .mem_write_ID(mem_write_ID), .uncond_jump_ID(uncond_jump_ID),
    .meet_branch_ID(meet_branch_ID), .pc_jal_sel_ID(pc_jal_sel_ID),
    .result_sel_ID(result_sel_ID), .alu_sel_0_ID(alu_sel_0_ID), .alu_sel_1_ID(alu_sel_1_ID),
    .alu_ctrl_ID(alu_ctrl_ID),
    .PC_ID_EX_o(PC_s), .PC_plus_4_ID_EX_o(PC4_s), .INST_ID_EX_o(INST_s),
    .rs1_ID_EX_o(rs1_s), .rs2_ID_EX_o(rs2_s), .rd_ID_EX_o(rd_s), .imm_ID_EX_o(imm_s),
    .rs1_data_ID_EX_o(rs1d_s), .rs2_data_ID_EX_o(rs2d_s),
    .reg_write_ID_EX_o(rw_s), .mem_write_ID_EX_o(mw_s), .uncond_jump_ID_EX_o(uj_s),
    .meet_branch_ID_EX_o(mb_s), .pc_jal_sel_ID_EX_o(pj_s),
    .result_sel_ID_EX_o(rs_s), .alu_sel_0_ID_EX_o(as0_s), .alu_sel_1_ID_EX_o(as1_s),
    .alu_ctrl_ID_EX_o(ac_s), .valid_ID_EX_o(valid_s), .bubble_cnt_o(cnt_s)
  );

  logic [OW-1:0] obs, obs_s, in_vec, exp_v, bubble_v;
  assign obs    = {PC_o, PC4_o, INST_o, rs1_o, rs2_o, rd_o, imm_o, rs1d_o, rs2d_o,
                   rw_o, mw_o, uj_o, mb_o, pj_o, rs_o, as0_o, as1_o, ac_o, valid_o};
  assign obs_s  = {PC_s, PC4_s, INST_s, rs1_s, rs2_s, rd_s, imm_s, rs1d_s, rs2d_s,
                   rw_s, mw_s, uj_s, mb_s, pj_s, rs_s, as0_s, as1_s, ac_s, valid_s};
  assign in_vec = {PC_ID, PC_plus_4_ID, INST_ID, rs1_ID, rs2_ID, rd_ID, imm_ID,
                   rs1_data_ID, rs2_data_ID, reg_write_ID, mem_write_ID, uncond_jump_ID,
                   meet_branch_ID, pc_jal_sel_ID, result_sel_ID, alu_sel_0_ID,
                   alu_sel_1_ID, alu_ctrl_ID, valid_ID};

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned nflush = 0;

  function automatic logic [15:0] exp_cnt();
    return (nflush > 65535) ? 16'hFFFF : 16'(nflush);
  endfunction

  function automatic logic [3:0] exp_cnt4();
    return (nflush > 15) ? 4'hF : 4'(nflush);
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".stage"}, obs, exp_v);
    check({tag, ".stage_w4"}, obs_s, exp_v);
    check({tag, ".cnt"}, OW'(cnt_o), OW'(exp_cnt()));
    check({tag, ".cnt_w4"}, OW'(cnt_s), OW'(exp_cnt4()));
  endtask

  // One clock edge: model applies flush > stall > load to the inputs now driven.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      if (flush_ID_EX) begin
        exp_v = bubble_v;
        nflush++;
      end else if (!stall_ID_EX) begin
        exp_v = in_vec;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    valid_ID       = 1'($urandom);
    PC_ID          = $urandom;
    PC_plus_4_ID   = $urandom;
    INST_ID        = $urandom;
    rs1_ID         = 5'($urandom);
    rs2_ID         = 5'($urandom);
    rd_ID          = 5'($urandom);
    imm_ID         = $urandom;
    rs1_data_ID    = $urandom;
    rs2_data_ID    = $urandom;
    reg_write_ID   = 1'($urandom);
    mem_write_ID   = 1'($urandom);
    uncond_jump_ID = 1'($urandom);
    meet_branch_ID = 1'($urandom);
    pc_jal_sel_ID  = 1'($urandom);
    result_sel_ID  = 2'($urandom);
    alu_sel_0_ID   = 2'($urandom);
    alu_sel_1_ID   = 2'($urandom);
    alu_ctrl_ID    = 1'($urandom);
  endtask

  task automatic clear_data();
    valid_ID = 0; PC_ID = 0; PC_plus_4_ID = 0; INST_ID = 0;
    rs1_ID = 0; rs2_ID = 0; rd_ID = 0; imm_ID = 0; rs1_data_ID = 0; rs2_data_ID = 0;
    reg_write_ID = 0; mem_write_ID = 0; uncond_jump_ID = 0; meet_branch_ID = 0;
    pc_jal_sel_ID = 0; result_sel_ID = 0; alu_sel_0_ID = 0; alu_sel_1_ID = 0;
    alu_ctrl_ID = 0;
  endtask

  initial begin
    bubble_v = {64'h0, 32'h0000_0013, 124'h0};
    exp_v    = bubble_v;
    rst = 1; stall_ID_EX = 0; flush_ID_EX = 1;
    rand_data();
    step(); step();
    check_all("reset_hold");
    rst = 0;

    // Pass-through of an addi x5,x6,10.
    clear_data(); flush_ID_EX = 0;
    PC_ID = 32'h100; PC_plus_4_ID = 32'h104; INST_ID = 32'h00A3_0293;
    rs1_ID = 5'd6; rd_ID = 5'd5; imm_ID = 32'd10; reg_write_ID = 1; valid_ID = 1;
    step();
    check_all("pass");
    check("pass.pc", OW'(PC_o), OW'(32'h100));
    check("pass.valid", OW'(valid_o), OW'(1'b1));

    // Stall holds for three cycles, then the next unstalled edge loads.
    PC_ID = 32'h104; step();
    PC_ID = 32'h108; stall_ID_EX = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", OW'(PC_o), OW'(32'h104));
    end
    stall_ID_EX = 0; step();
    check("unstall.pc", OW'(PC_o), OW'(32'h108));
    check_all("unstall");

    // Flush wins over stall.
    mem_write_ID = 1; stall_ID_EX = 1; flush_ID_EX = 1; step();
    check("flush.mw", OW'(mw_o), OW'(1'b0));
    check("flush.valid", OW'(valid_o), OW'(1'b0));
    check("flush.inst", OW'(INST_o), OW'(32'h13));
    check("flush.cnt", OW'(cnt_o), OW'(16'd1));
    check_all("flush");

    // Invalid load keeps its fields but is marked invalid.
    stall_ID_EX = 0; flush_ID_EX = 0; valid_ID = 0; reg_write_ID = 1; step();
    check("inval.rw", OW'(rw_o), OW'(1'b1));
    check("inval.valid", OW'(valid_o), OW'(1'b0));
    check("inval.cnt", OW'(cnt_o), OW'(16'd1));

    // Twenty back-to-back flushes saturate the 4-bit counter at 15.
    flush_ID_EX = 1;
    for (int i = 0; i < 20; i++) begin
      rand_data(); step();
      check_all("sat");
    end
    check("sat.final4", OW'(cnt_s), OW'(4'd15));
    check("sat.final16", OW'(cnt_o), OW'(16'd21));

    // Randomized stall/flush/load traffic.
    for (int i = 0; i < 300; i++) begin
      rand_data();
      flush_ID_EX = ($urandom_range(0, 3) == 0);
      stall_ID_EX = ($urandom_range(0, 2) == 0);
      step();
      check_all("rand");
    end

    // Asynchronous reset mid-stall, between edges.
    rand_data(); flush_ID_EX = 0; stall_ID_EX = 0; step();
    stall_ID_EX = 1; step();
    #2 rst = 1;
    #1;
    nflush = 0; exp_v = bubble_v;
    check_all("async_rst");
    flush_ID_EX = 1; rand_data(); step();
    check_all("rst_ignores_flush");
    rst = 0;

    for (int i = 0; i < 100; i++) begin
      rand_data();
      flush_ID_EX = ($urandom_range(0, 3) == 0);
      stall_ID_EX = ($urandom_range(0, 2) == 0);
      step();
      check_all("rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
